// File: rtl/image_rd_pkg.sv
// Shared constants and types for the image RAM read engine.
package image_rd_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rd_state_t;

    // One output beat as held in the skid FIFO.
    typedef struct packed {
        logic              last;
        logic              last_col;
        logic [DATA_W-1:0] data;
    } pix_beat_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry output FIFO; entry 0 is always the head presented downstream.
module rd_skid_fifo
    import image_rd_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  pix_beat_t push_beat,
    input  logic      pop,
    output pix_beat_t head_beat,
    output logic [1:0] count
);

    pix_beat_t  ent0_r;
    pix_beat_t  ent1_r;
    logic [1:0] cnt_r;
    logic       pop_s;

    // A pop against an empty FIFO is meaningless and is ignored.
    assign pop_s     = pop && (cnt_r != 2'd0);
    assign head_beat = ent0_r;
    assign count     = cnt_r;

    // Fill, shift and occupancy update; the issuer guarantees no push when full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent0_r <= '0;
            ent1_r <= '0;
            cnt_r  <= 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r <= push_beat;
                    end else begin
                        ent1_r <= push_beat;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ent0_r <= push_beat;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_beat;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/image_ram_reader.sv
// Walks a rectangular region of the image RAM and streams its pixels out.
module image_ram_reader
    import image_rd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DIM_W-1:0]  rows,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last_col,
    output logic              out_last
);

    rd_state_t         state_r, state_s;
    logic [DIM_W-1:0]  cols_r, rows_r, col_r, row_r;
    logic [ADDR_W-1:0] stride_r, row_base_r, addr_r;
    logic              tag_valid_r, tag_last_col_r, tag_last_r;
    logic              busy_r, done_r;
    logic              issue_s, accept_s, pop_s;
    logic              pix_last_col_s, pix_last_s;
    logic [1:0]        fifo_count_s;
    logic [2:0]        occ_s;
    pix_beat_t         head_s, push_beat_s;

    // ram_address is a register preloaded with the next pixel to read, so it
    // simply holds whenever no read is issued.
    assign ram_address  = addr_r;
    assign ram_wren     = 1'b0;
    assign busy         = busy_r;
    assign done         = done_r;
    assign out_valid    = (fifo_count_s != 2'd0);
    assign out_data     = head_s.data;
    assign out_last_col = head_s.last_col;
    assign out_last     = head_s.last;

    assign pop_s          = out_valid && out_ready;
    assign pix_last_col_s = (col_r == (cols_r - DIM_W'(1)));
    assign pix_last_s     = pix_last_col_s && (row_r == (rows_r - DIM_W'(1)));
    // Beats committed after this edge: buffered plus the one in the RAM stage,
    // less the one leaving now. Issue only while that stays below the depth.
    assign occ_s = {1'b0, fifo_count_s} + {2'b00, tag_valid_r} - {2'b00, pop_s};

    assign push_beat_s = '{last: tag_last_r, last_col: tag_last_col_r, data: ram_q};

    rd_skid_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_valid_r),
        .push_beat (push_beat_s),
        .pop       (pop_s),
        .head_beat (head_s),
        .count     (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus start acceptance and read-issue decisions.
    always_comb begin
        state_s  = state_r;
        issue_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if ((cols == '0) || (rows == '0)) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (occ_s < 3'd2) begin
                    issue_s = 1'b1;
                    if (pix_last_s) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (occ_s == 3'd0) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Region capture, address generation, tag pipeline and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cols_r         <= '0;
            rows_r         <= '0;
            stride_r       <= '0;
            row_base_r     <= '0;
            addr_r         <= '0;
            col_r          <= '0;
            row_r          <= '0;
            tag_valid_r    <= 1'b0;
            tag_last_col_r <= 1'b0;
            tag_last_r     <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                cols_r     <= cols;
                rows_r     <= rows;
                stride_r   <= stride;
                row_base_r <= base_addr;
                col_r      <= '0;
                row_r      <= '0;
                if (state_s == ST_ISSUE) begin
                    addr_r <= base_addr;
                end else begin
                    addr_r <= addr_r;
                end
            end else if (issue_s && !pix_last_s) begin
                if (pix_last_col_s) begin
                    col_r      <= '0;
                    row_r      <= row_r + DIM_W'(1);
                    row_base_r <= row_base_r + stride_r;
                    addr_r     <= row_base_r + stride_r;
                end else begin
                    col_r  <= col_r + DIM_W'(1);
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end else begin
                addr_r <= addr_r;
            end
            tag_valid_r    <= issue_s;
            tag_last_col_r <= issue_s && pix_last_col_s;
            tag_last_r     <= issue_s && pix_last_s;
            busy_r         <= (state_s != ST_IDLE);
            done_r         <= (state_s == ST_FIN);
        end
    end

endmodule

// File: tb/tb_image_ram_reader.sv
// Directed, table-driven bench for image_ram_reader with a behavioural RAM.
module tb_image_ram_reader;
    import image_rd_pkg::*;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  cols;
    logic [DIM_W-1:0]  rows;
    logic [ADDR_W-1:0] stride;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last_col;
    logic              out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] base;
        logic [7:0]  ncols;
        logic [7:0]  nrows;
        logic [13:0] step;
        bit          stall;
        int          exp_beats;
        int          exp_done;
        int          exp_sum;
        string       name;
    } vec_t;

    vec_t vecs[9];
    vec_t post_rst;

    image_ram_reader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .cols         (cols),
        .rows         (rows),
        .stride       (stride),
        .busy         (busy),
        .done         (done),
        .ram_address  (ram_address),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last_col (out_last_col),
        .out_last     (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM preloaded with mem[a] = a[7:0], one-cycle registered read.
    always @(posedge clock) ram_q <= ram_address[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one region; entered and left at 1 time unit after a rising edge.
    task automatic run_case(input vec_t v);
        logic [13:0] exp_addr[$];
        logic        exp_lc[$];
        logic        exp_l[$];
        logic [13:0] a;
        int idx, sum, done_cyc, last_hs, cyc;
        bit seen_done, exp_dn;
        exp_addr.delete(); exp_lc.delete(); exp_l.delete();
        for (int r = 0; r < int'(v.nrows); r++) begin
            for (int c = 0; c < int'(v.ncols); c++) begin
                a = 14'((int'(v.base) + r * int'(v.step) + c) & 32'h3FFF);
                exp_addr.push_back(a);
                exp_lc.push_back(c == int'(v.ncols) - 1);
                exp_l.push_back((c == int'(v.ncols) - 1) && (r == int'(v.nrows) - 1));
            end
        end
        idx = 0; sum = 0; done_cyc = -1; last_hs = -1; seen_done = 1'b0;
        start = 1'b1; base_addr = v.base; cols = v.ncols; rows = v.nrows; stride = v.step;
        for (cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            if (cyc == 1) begin
                // Scramble inputs: the captured region must not follow them.
                start     = 1'b0;
                base_addr = v.base ^ 14'h1555;
                cols      = v.ncols + 8'd3;
                rows      = v.nrows + 8'd1;
                stride    = v.step ^ 14'h0AAA;
            end
            if (cyc == 4 && v.exp_beats >= 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            check({v.name, "_wren"}, 32'(ram_wren), 32'd0);
            check({v.name, "_busy"}, 32'(busy), 32'(cyc >= 1));
            exp_dn = (v.exp_beats == 0) ? (cyc == 1) : (last_hs >= 0 && cyc == last_hs + 1);
            check({v.name, "_done"}, 32'(done), 32'(exp_dn));
            if (!v.stall) begin
                check({v.name, "_valid_timing"}, 32'(out_valid),
                      32'(cyc >= 3 && cyc < 3 + v.exp_beats));
                if (cyc >= 1 && cyc <= v.exp_beats)
                    check({v.name, "_addr"}, 32'(ram_address), 32'(exp_addr[cyc-1]));
            end
            if (idx >= v.exp_beats) begin
                check({v.name, "_no_extra_beat"}, 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                check({v.name, "_data"}, 32'(out_data), 32'(exp_addr[idx][7:0]));
                check({v.name, "_last_col"}, 32'(out_last_col), 32'(exp_lc[idx]));
                check({v.name, "_last"}, 32'(out_last), 32'(exp_l[idx]));
                if (out_ready) begin
                    sum += int'(out_data);
                    idx++;
                    if (idx == v.exp_beats) last_hs = cyc;
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        check({v.name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({v.name, "_beats"}, 32'(idx), 32'(v.exp_beats));
        check({v.name, "_sum"}, 32'(sum), 32'(v.exp_sum));
        if (!v.stall) check({v.name, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    endtask

    initial begin
        vecs[0] = '{14'h0100, 8'd4, 8'd3, 14'h0040, 1'b0, 12, 15, 786, "basic"};
        vecs[1] = '{14'h0100, 8'd4, 8'd3, 14'h0040, 1'b1, 12,  0, 786, "stall"};
        vecs[2] = '{14'h3FFE, 8'd4, 8'd2, 14'h0010, 1'b0,  8, 11, 572, "wrap"};
        vecs[3] = '{14'h0100, 8'd0, 8'd5, 14'h0040, 1'b0,  0,  1,   0, "cols0"};
        vecs[4] = '{14'h0100, 8'd5, 8'd0, 14'h0040, 1'b0,  0,  1,   0, "rows0"};
        vecs[5] = '{14'h0005, 8'd1, 8'd1, 14'h0000, 1'b0,  1,  4,   5, "single"};
        vecs[6] = '{14'h0020, 8'd3, 8'd1, 14'h0000, 1'b0,  3,  6,  99, "onerow"};
        vecs[7] = '{14'h0007, 8'd1, 8'd3, 14'h0100, 1'b0,  3,  6,  21, "onecol"};
        vecs[8] = '{14'h3FFE, 8'd4, 8'd2, 14'h0010, 1'b1,  8,  0, 572, "wrap_stall"};
        post_rst = '{14'h0300, 8'd2, 8'd2, 14'h0080, 1'b0, 4,  7, 258, "post_reset"};

        reset = 1'b1; start = 1'b0; base_addr = '0; cols = '0; rows = '0;
        stride = '0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last_col", 32'(out_last_col), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) run_case(vecs[i]);

        // Reset after five beats of an 8x8 region starting at 0x0200.
        start = 1'b1; base_addr = 14'h0200; cols = 8'd8; rows = 8'd8;
        stride = 14'h0020; out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 1) start = 1'b0;
            @(negedge clock);
            if (cyc >= 3) begin
                check("mid_valid", 32'(out_valid), 32'd1);
                check("mid_data", 32'(out_data), 32'(cyc - 3));
            end
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_addr", 32'(ram_address), 32'd0);
        check("mid_rst_wren", 32'(ram_wren), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_last_col", 32'(out_last_col), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            check("after_rst_valid", 32'(out_valid), 32'd0);
            check("after_rst_busy", 32'(busy), 32'd0);
            @(posedge clock); #1;
        end
        run_case(post_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_ram_reader.md
# image_ram_reader

Read-side engine for the 16 K x 8 image RAM. On a start pulse it walks a rectangular region (base, columns, rows, row stride), drives the RAM's address port, absorbs the RAM's one-cycle registered read latency, and presents pixels as a valid/ready stream with row and frame markers to the NPU datapath. It owns the RAM port while busy; the RAM write-enable it drives is always 0.

## Interface
- ADDR_W, 14, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, pixel width.
- DIM_W, 8, width of the column and row counts (max 255 x 255 region).
- clock  input  1  single clock for the block and the RAM.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDR_W  address of pixel (0,0); captured on accepted start.
- cols  input  DIM_W  pixels per row; captured on accepted start.
- rows  input  DIM_W  rows in region; captured on accepted start.
- stride  input  ADDR_W  address step between row starts; captured on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at completion.
- ram_address  output  ADDR_W  to RAM address port.
- ram_wren  output  1  constant 0.
- ram_q  input  DATA_W  RAM read data, valid the cycle after its address was presented.
- out_data  output  DATA_W  pixel.
- out_valid  output  1  pixel available.
- out_ready  input  1  consumer accepts; beat transfers when out_valid && out_ready.
- out_last_col  output  1  beat is the last pixel of its row.
- out_last  output  1  beat is the last pixel of the region.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 captures base_addr/cols/rows/stride, sets busy, goes to ISSUE; if cols==0 or rows==0 goes straight to FIN (no beats).
- ISSUE: presents row_base + col on ram_address when a read slot is free; col increments; at col==cols-1 col resets to 0, row_base += stride (wraps), row increments. After issuing the final pixel goes to DRAIN.
- Read slot free when buffered + in_flight - pop_this_cycle < 2, so the 2-entry output FIFO can never overflow; no read is ever dropped or repeated.
- Each issued read carries its last_col/last flags through a 1-cycle tag pipeline alongside the RAM latency; the flags and ram_q are pushed into the FIFO together.
- DRAIN: waits until FIFO empty and no read in flight, then FIN.
- FIN: done=1 for one cycle, busy=0, back to IDLE.
- start while not in IDLE is ignored; captured parameters are not affected by input changes after capture.
- ram_address holds its last value when no read is issued.
- Reset (any time, including mid-region): FSM to IDLE, FIFO and in-flight tag cleared, no further beats; pending pixels are discarded.

## Timing
- Reset values: busy=0, done=0, ram_address=0, ram_wren=0, out_valid=0, out_data=0, out_last_col=0, out_last=0.
- Start accepted in cycle 0: first ram_address in cycle 1, ram_q valid cycle 2, first out_valid in cycle 3.
- With out_ready held high: one beat per cycle, no bubbles; an N-pixel region ends with the last beat in cycle N+2 and done in cycle N+3.
- out_valid deasserts only after a handshake; out_data and flags are stable while out_valid && !out_ready.
- Row transitions add no bubble cycles.
- done asserts exactly one cycle after the out_last handshake; a new start is accepted in the cycle after done.
- Zero-size region: done in cycle 1 after start, no out_valid.

## Structure
- Package image_rd_pkg: ADDR_W, DATA_W, DIM_W constants and the FSM state enum.
- Sub-module rd_skid_fifo: 2-entry FIFO of {last, last_col, data} with push, pop, count; top level holds FSM, counters, address generator and tag pipeline.

## Test plan
- RAM preloaded mem[a]=a[7:0]; base=0x0100, cols=4, rows=3, stride=0x40, out_ready=1 -> 12 beats 0x00..0x03, 0x40..0x43, 0x80..0x83, in consecutive cycles from cycle 3; out_last_col on beats 4, 8, 12; out_last on beat 12; done at cycle 15.
- Same region, out_ready toggled by random pattern (50%) -> identical data/flag sequence, no loss or duplication, data stable during stall.
- base=0x3FFE, cols=4, rows=2, stride=0x10 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, 0x000E..0x0011 (wrap).
- cols=0 (rows=5) and rows=0 (cols=5) -> no out_valid, done one cycle after start, busy high for exactly that cycle.
- reset asserted after 5 beats of a 64-pixel region -> all outputs at reset values next cycle; subsequent start of 2x2 region produces exactly 4 correct beats.
- start pulsed again mid-region with different parameters -> ignored; original region completes unchanged; ram_wren 0 throughout all tests.
